// File: rtl/bsg_manycore_pod_row_reset_sequencer.sv
// Staggered west-to-east reset release for a row of manycore pods.
// Optional abort input enabled by defining BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN.
module bsg_manycore_pod_row_reset_sequencer #(
  parameter int num_pods_x_p    = 4,
  parameter int num_tiles_x_p   = 16,
  parameter int hold_cycles_p   = 16,
  parameter int gap_width_p     = 8,
  parameter int pod_id_width_lp = (num_pods_x_p > 1) ? $clog2(num_pods_x_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   go_i,
  input  logic [gap_width_p-1:0]                 gap_i,
  input  logic [num_pods_x_p-1:0]                pod_en_i,
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
  input  logic                                   abort_i,
`endif
  output logic [num_pods_x_p*num_tiles_x_p-1:0]  reset_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [pod_id_width_lp-1:0]             cur_pod_o
);

  localparam int hold_w_lp = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
  localparam logic [hold_w_lp-1:0]       hold_last_lp = hold_w_lp'(hold_cycles_p - 1);
  localparam logic [pod_id_width_lp-1:0] pod_last_lp  = pod_id_width_lp'(num_pods_x_p - 1);

  typedef enum logic [2:0] {
    e_idle,
    e_hold,
    e_release,
    e_gap,
    e_done
  } state_e;

  state_e                     r_state,    w_state_n;
  logic [pod_id_width_lp-1:0] r_idx,      w_idx_n;
  logic [hold_w_lp-1:0]       r_hold_cnt, w_hold_cnt_n;
  logic [gap_width_p-1:0]     r_gap_cnt,  w_gap_cnt_n;
  logic [gap_width_p-1:0]     r_gap_q,    w_gap_q_n;
  logic [num_pods_x_p-1:0]    r_en_q,     w_en_q_n;
  logic [num_pods_x_p-1:0]    r_rst_pod,  w_rst_pod_n;
  logic                       w_load;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_idx      <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_gap_q    <= '0;
      r_en_q     <= '0;
      r_rst_pod  <= '1;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_hold_cnt <= w_hold_cnt_n;
      r_gap_cnt  <= w_gap_cnt_n;
      r_gap_q    <= w_gap_q_n;
      r_en_q     <= w_en_q_n;
      r_rst_pod  <= w_rst_pod_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_hold_cnt_n = r_hold_cnt;
    w_gap_cnt_n  = r_gap_cnt;
    w_gap_q_n    = r_gap_q;
    w_en_q_n     = r_en_q;
    w_rst_pod_n  = r_rst_pod;
    w_load       = 1'b0;

    case (r_state)
      e_idle: begin
        w_rst_pod_n = '1;
        w_idx_n     = '0;
        w_load      = go_i;
      end
      e_hold: begin
        if (r_hold_cnt == hold_last_lp) w_state_n = e_release;
        else                            w_hold_cnt_n = r_hold_cnt + hold_w_lp'(1);
      end
      e_release: begin
        if (r_en_q[r_idx]) w_rst_pod_n[r_idx] = 1'b0;
        if (r_idx == pod_last_lp) begin
          w_state_n = e_done;
        end else begin
          w_idx_n = r_idx + pod_id_width_lp'(1);
          if (r_gap_q != '0) begin
            w_state_n   = e_gap;
            w_gap_cnt_n = '0;
          end
        end
      end
      e_gap: begin
        // equality against gap-1 keeps the all-ones gap from wrapping the counter
        if (r_gap_cnt == r_gap_q - gap_width_p'(1)) w_state_n = e_release;
        else                                        w_gap_cnt_n = r_gap_cnt + gap_width_p'(1);
      end
      e_done: begin
        w_load = go_i;
      end
      default: begin
        w_state_n   = e_idle;
        w_rst_pod_n = '1;
        w_idx_n     = '0;
      end
    endcase

    if (w_load) begin
      w_state_n    = e_hold;
      w_gap_q_n    = gap_i;
      w_en_q_n     = pod_en_i;
      w_hold_cnt_n = '0;
      w_idx_n      = '0;
      w_rst_pod_n  = '1;
    end

`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    if (abort_i && (r_state != e_idle)) begin
      w_state_n    = e_idle;
      w_rst_pod_n  = '1;
      w_idx_n      = '0;
      w_hold_cnt_n = '0;
      w_gap_cnt_n  = '0;
      w_gap_q_n    = r_gap_q;
      w_en_q_n     = r_en_q;
    end
`endif
  end

  for (genvar p = 0; p < num_pods_x_p; p++) begin : g_pod
    assign reset_o[p*num_tiles_x_p +: num_tiles_x_p] = {num_tiles_x_p{r_rst_pod[p]}};
  end

  assign busy_o    = (r_state == e_hold) || (r_state == e_release) || (r_state == e_gap);
  assign done_o    = (r_state == e_done);
  assign cur_pod_o = r_idx;

endmodule

// File: tb/tb_bsg_manycore_pod_row_reset_sequencer.sv
// Bench for bsg_manycore_pod_row_reset_sequencer: vector table plus reset/abort/re-sequence cases.
module tb_bsg_manycore_pod_row_reset_sequencer;

  localparam int NP   = 4;
  localparam int NT   = 16;
  localparam int HOLD = 16;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              go_i;
  logic [7:0]        gap_i;
  logic [NP-1:0]     pod_en_i;
  logic [NP*NT-1:0]  reset_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        cur_pod_o;
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
  logic              abort_i;
`endif

  bsg_manycore_pod_row_reset_sequencer #(
    .num_pods_x_p (NP),
    .num_tiles_x_p(NT),
    .hold_cycles_p(HOLD),
    .gap_width_p  (8)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .go_i     (go_i),
    .gap_i    (gap_i),
    .pod_en_i (pod_en_i),
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    .abort_i  (abort_i),
`endif
    .reset_o  (reset_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .cur_pod_o(cur_pod_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP*NT-1:0] rst;
    logic             busy;
    logic             done;
    logic [1:0]       cur;
  } exp_t;

  typedef struct {
    logic [7:0]    gap;
    logic [NP-1:0] en;
    int            done_t;   // cycles after go acceptance until done_o rises
    int            glitch_t; // cycle with a stray go_i pulse, 0 = none
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // t = cycles since the accepting edge; t=0 is the idle picture
  function automatic exp_t model(int t, logic [7:0] gap, logic [NP-1:0] en, int done_t);
    exp_t e;
    int   nrel = 0;
    e.rst = '1;
    if (t > 0)
      for (int k = 0; k < NP; k++)
        if (t >= HOLD + 2 + k * (int'(gap) + 1)) begin
          nrel++;
          if (en[k]) e.rst[k*NT +: NT] = '0;
        end
    e.busy = (t >= 1) && (t < done_t);
    e.done = (t > 0) && (t >= done_t);
    e.cur  = (nrel > NP - 1) ? 2'(NP - 1) : 2'(nrel);
    return e;
  endfunction

  task automatic check_sb(string name, int t);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s t=%0d scoreboard empty", name, t);
    end else begin
      e = sb.pop_front();
      if ({reset_o, busy_o, done_o, cur_pod_o} !== {e.rst, e.busy, e.done, e.cur}) begin
        errors++;
        $display("FAIL %s t=%0d got rst=%h busy=%b done=%b cur=%0d exp rst=%h busy=%b done=%b cur=%0d",
                 name, t, reset_o, busy_o, done_o, cur_pod_o, e.rst, e.busy, e.done, e.cur);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    go_i    = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    sb.push_back(model(0, 8'd0, '0, 1));
    @(negedge clk);
    check_sb("idle_after_reset", 0);
  endtask

  // Issue go with the given fields and check every cycle up to last_t
  task automatic run_seq(string name, logic [7:0] gap, logic [NP-1:0] en, int done_t,
                         int glitch_t, int last_t);
    gap_i    = gap;
    pod_en_i = en;
    go_i     = 1'b1;
    for (int t = 1; t <= last_t; t++) begin
      sb.push_back(model(t, gap, en, done_t));
      @(negedge clk);
      check_sb(name, t);
      go_i = (t + 1 == glitch_t);
      if (go_i) begin
        gap_i    = 8'd9;
        pod_en_i = '0;
      end
    end
    go_i = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    reset_i  = 1'b1;
    go_i     = 1'b0;
    gap_i    = '0;
    pod_en_i = '0;
`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    abort_i  = 1'b0;
`endif
    #1;
    sb.push_back(model(0, 8'd0, '0, 1));
    check_sb("async_reset_state", 0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;

    vecs[0] = '{gap: 8'd2,   en: 4'b1111, done_t: 27,  glitch_t: 0};
    vecs[1] = '{gap: 8'd0,   en: 4'b1111, done_t: 21,  glitch_t: 0};
    vecs[2] = '{gap: 8'd2,   en: 4'b0101, done_t: 27,  glitch_t: 0};
    vecs[3] = '{gap: 8'd2,   en: 4'b1111, done_t: 27,  glitch_t: 19};
    vecs[4] = '{gap: 8'd255, en: 4'b1111, done_t: 786, glitch_t: 0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_seq($sformatf("vec%0d", i), vecs[i].gap, vecs[i].en, vecs[i].done_t,
              vecs[i].glitch_t, vecs[i].done_t + 4);
    end

    // re-sequence straight out of DONE with a different mask and gap
    run_seq("reseq", 8'd1, 4'b1010, 24, 0, 28);

    // reset_i mid-gap must clear everything without waiting for an edge
    do_reset();
    run_seq("pre_abort_rst", 8'd2, 4'b1111, 27, 0, 22);
    reset_i = 1'b1;
    #1;
    sb.push_back(model(0, 8'd0, '0, 1));
    check_sb("async_mid_reset", 0);
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(0, 8'd0, '0, 1));
      @(negedge clk);
      check_sb("idle_hold", i);
    end

`ifdef BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN
    do_reset();
    run_seq("pre_abort_hold", 8'd2, 4'b1111, 27, 0, 5);
    abort_i = 1'b1;
    go_i    = 1'b1;
    sb.push_back(model(0, 8'd0, '0, 1));
    @(negedge clk);
    check_sb("abort_hold", 0);
    abort_i = 1'b0;
    go_i    = 1'b0;
    run_seq("pre_abort_done", 8'd0, 4'b1111, 21, 0, 23);
    abort_i = 1'b1;
    sb.push_back(model(0, 8'd0, '0, 1));
    @(negedge clk);
    check_sb("abort_done", 0);
    abort_i = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pod_row_reset_sequencer.md
Name: bsg_manycore_pod_row_reset_sequencer

Overview:
Generates the per-pod, per-column reset vector for a horizontal row of manycore pods. After a start request it holds every pod in reset for a fixed interval, then releases enabled pods one at a time, west (pod 0) to east, with a programmable gap between releases. Staggering the releases limits di/dt and gives each pod's links a quiet startup. Sits beside the pod row and drives its per-pod, per-tile reset input.

Parameters:
num_pods_x_p, 4, number of pods in the row (>=1)
num_tiles_x_p, 16, tile columns per pod; every column of a pod shares that pod's reset value
hold_cycles_p, 16, cycles all resets stay asserted before the first release (>=1)
gap_width_p, 8, width of the inter-pod gap programming field
pod_id_width_lp, `BSG_SAFE_CLOG2(num_pods_x_p), width of the pod index

Ports:
clk_i  in  1  clock; the block's only clock
reset_i  in  1  asynchronous, active-high reset
go_i  in  1  start request; sampled in IDLE and DONE only
gap_i  in  gap_width_p  idle cycles between successive pod releases; captured when go_i is accepted
pod_en_i  in  num_pods_x_p  bit k=1 releases pod k; a 0 bit keeps pod k in reset; captured when go_i is accepted
reset_o  out  num_pods_x_p*num_tiles_x_p  reset vector [pod][tile]; 1 = in reset; registered
busy_o  out  1  1 in HOLD, RELEASE or GAP
done_o  out  1  1 in DONE
cur_pod_o  out  pod_id_width_lp  index of the pod currently being sequenced

Behaviour:
- Async reset: state=IDLE, reset_o all ones, pod index=0, counters=0, captured gap and enable fields=0, busy_o=0, done_o=0.
- IDLE: reset_o all ones. If go_i=1: capture gap_i and pod_en_i, clear the hold counter, pod index=0, go to HOLD.
- HOLD: stay exactly hold_cycles_p cycles, then go to RELEASE.
- RELEASE, one cycle:
  - If captured enable bit [idx] is 1, reset_o[idx][*] goes to 0 on the next edge, all columns at once. If it is 0, the pod stays in reset but still uses its slot.
  - If idx = num_pods_x_p-1, go to DONE.
  - Otherwise idx increments. Go to GAP if the captured gap is nonzero; otherwise stay in RELEASE.
- GAP: stay exactly the captured gap cycles, then go to RELEASE.
  - Release spacing between consecutive pods is gap+1 cycles.
  - Gap value 2^gap_width_p-1 must work without overflow: the counter is gap_width_p bits and is compared for equality, never incremented past the terminal value.
- DONE: reset_o holds its released pattern indefinitely. If go_i=1: recapture the fields, reassert all of reset_o on the next edge, go to HOLD (re-sequence).
- go_i in HOLD, RELEASE or GAP is ignored; the captured fields do not change.
- Released pods are never re-asserted except by re-sequencing from DONE, reset_i, or abort.
- cur_pod_o = current index; it reads 0 in IDLE and num_pods_x_p-1 in DONE.
- Reset asserted mid-sequence: everything returns immediately (asynchronously) to the reset values; reset_o is all ones.
- num_pods_x_p=1: the first RELEASE goes straight to DONE.
- Latency: with go_i accepted on edge e, the first RELEASE is on cycle e+hold_cycles_p+1 and pod 0 is deasserted from cycle e+hold_cycles_p+2.

Optional Feature:
Macro BSG_MANYCORE_POD_RESET_SEQ_ABORT_EN.
- Defined: adds input abort_i (1 bit). abort_i=1 in HOLD, RELEASE, GAP or DONE sets reset_o all ones on the next edge and goes to IDLE. abort_i has priority over go_i and over the normal state transitions in the same cycle. abort_i in IDLE has no effect.
- Undefined: the port is absent and the FSM behaves as described above.

Test Plan:
- Basic sequence (4 pods, hold=16, gap_i=2, pod_en_i=4'b1111), go_i on cycle 10:
  - reset_o[0] low from cycle 28, [1] from 31, [2] from 34, [3] from 37.
  - done_o=1 from cycle 37; busy_o=1 during cycles 11-36.
- Zero gap (gap_i=0, all enabled): pods deassert on four consecutive cycles 28,29,30,31; done_o=1 from 31.
- Enable mask (pod_en_i=4'b0101, gap_i=2): pods 0 and 2 low at 28 and 34; pods 1 and 3 stay all ones after done_o=1 at 37.
- Mid-sequence events:
  - go_i pulsed during GAP is ignored, with unchanged timing.
  - reset_i asserted at cycle 32 forces reset_o all ones in the same cycle and returns to IDLE.
- Re-sequence: go_i in DONE reasserts all reset_o bits next cycle and repeats the timing.
- Max gap (gap_width_p=8, gap_i=255): release spacing is 256 cycles with no counter wrap. With ABORT_EN, abort_i during HOLD puts the block in IDLE next cycle with all resets asserted.
